// File: rtl/secded_pkg.sv
// rtl/secded_pkg.sv - SECDED receiver state type and Hamming index helpers
package secded_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_DECODE
  } rx_state_e;

  // Upper bound on codeword length the helpers can handle; shared with the transmitter.
  localparam int MAX_CW = 64;

  function automatic int calc_par_w(input int data_w);
    int p;
    p = 1;
    for (int k = 1; k < 16; k++) begin
      if ((1 << p) < data_w + p + 1) p = p + 1;
    end
    return p;
  endfunction

  function automatic logic is_parity_pos(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  function automatic int data_pos(input int idx);
    int k;
    int res;
    k   = 0;
    res = 0;
    for (int pos = 1; pos < MAX_CW; pos++) begin
      if (!is_parity_pos(pos)) begin
        if (k == idx) res = pos;
        k = k + 1;
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] syndrome(input logic [MAX_CW-1:0] cw, input int n);
    logic [7:0] s;
    s = '0;
    for (int pos = 1; pos < MAX_CW; pos++) begin
      if (pos <= n && cw[pos]) s = s ^ pos[7:0];
    end
    return s;
  endfunction

endpackage

// File: rtl/secded_rx_fifo.sv
// rtl/secded_rx_fifo.sv - synchronous FIFO for decoded words, wrap-bit full/empty
module secded_rx_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
  assign do_wr = wr_en & (~full | do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/secded_serial_rx.sv
// rtl/secded_serial_rx.sv - oversampling SECDED serial receiver with decoded-word FIFO
module secded_serial_rx
  import secded_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corr,
  output logic              out_uncorr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              overflow,
  output logic              busy,
  input  logic              cnt_clr,
  output logic [7:0]        corr_cnt,
  output logic [7:0]        uncorr_cnt
);

  localparam int PAR_W = calc_par_w(DATA_W);
  localparam int N     = DATA_W + PAR_W;
  localparam int CW    = N + 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(CW);
  localparam int FW    = DATA_W + 2;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CW - 1);

  logic sync1, rxd, rxd_prev, fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b1;
      rxd      <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      sync1    <= serial_in;
      rxd      <= sync1;
      rxd_prev <= rxd;
    end
  end

  assign fall = rxd_prev & ~rxd;

  rx_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic [CW-1:0]     cw_reg;

  logic [CW-1:0]     fixed;
  logic [7:0]        syn;
  logic              par;
  logic              dec_corr;
  logic              dec_uncorr;
  logic [DATA_W-1:0] dec_data;

  // Syndrome names the flipped position; overall parity tells single from double errors.
  always_comb begin
    syn        = syndrome(MAX_CW'(cw_reg), N);
    par        = ^cw_reg;
    fixed      = cw_reg;
    dec_corr   = 1'b0;
    dec_uncorr = 1'b0;
    dec_data   = '0;
    if (par) begin
      if (syn <= 8'(N)) dec_corr = 1'b1;
      else              dec_uncorr = 1'b1;
      for (int i = 1; i < CW; i++) begin
        if (syn == 8'(i)) fixed[i] = ~fixed[i];
      end
    end else if (syn != '0) begin
      dec_uncorr = 1'b1;
    end
    for (int i = 0; i < DATA_W; i++) dec_data[i] = fixed[data_pos(i)];
  end

  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [FW-1:0] fifo_rd;

  assign push = (state == ST_DECODE);
  assign pop  = out_ready & ~fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      cw_reg    <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overflow  <= push & fifo_full & ~pop;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (fall) state <= ST_START;
        end
        ST_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxd ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == FULL_M1) begin
            cnt    <= '0;
            cw_reg <= {rxd, cw_reg[CW-1:1]};
            if (bit_idx == LAST_BIT) state <= ST_STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rxd) begin
              state <= ST_DECODE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DECODE: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Dropped words still count: the counters track line quality, not delivery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (push) begin
      if (dec_corr && corr_cnt != 8'hFF)     corr_cnt   <= corr_cnt + 1'b1;
      if (dec_uncorr && uncorr_cnt != 8'hFF) uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end

  secded_rx_fifo #(
    .WIDTH(FW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (push),
    .wr_data({dec_uncorr, dec_corr, dec_data}),
    .rd_en  (out_ready),
    .rd_data(fifo_rd),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign {out_uncorr, out_corr, out_data} = fifo_rd;
  assign out_valid = ~fifo_empty;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_secded_serial_rx.sv
// tb/tb_secded_serial_rx.sv - directed scoreboard bench for secded_serial_rx
module tb_secded_serial_rx;

  localparam int DATA_W = 4;
  localparam int CPB    = 16;
  localparam int DEPTH  = 4;
  localparam int CW     = 8;
  localparam int T_STOP = 2 + CPB / 2 + (CW + 1) * CPB;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              serial_in = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              out_corr;
  logic              out_uncorr;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              frame_err;
  logic              overflow;
  logic              busy;
  logic              cnt_clr = 1'b0;
  logic [7:0]        corr_cnt;
  logic [7:0]        uncorr_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int fe_seen  = 0;
  int ovf_seen = 0;
  logic [5:0] sb [$];

  secded_serial_rx #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .out_data  (out_data),
    .out_corr  (out_corr),
    .out_uncorr(out_uncorr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overflow  (overflow),
    .busy      (busy),
    .cnt_clr   (cnt_clr),
    .corr_cnt  (corr_cnt),
    .uncorr_cnt(uncorr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consumer side: every accepted head word must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_seen++;
      if (overflow)  ovf_seen++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_word", 16'(out_valid), 16'd0);
        end else begin
          check("word", 16'({out_uncorr, out_corr, out_data}), 16'(sb.pop_front()));
        end
      end
    end
  end

  task automatic send_frame(input logic [CW-1:0] cw, input logic stop_val,
                            input bit chk_lat, input int nbits);
    logic [CW+1:0] bits;
    int idx;
    bits = {stop_val, cw, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (c == 0) serial_in = bits[b];
        idx = b * CPB + c;
        if (chk_lat && (idx == T_STOP || idx == T_STOP + 1)) begin
          @(posedge clk);
          #1;
          if (idx == T_STOP) check("valid_before_t2", 16'(out_valid), 16'd0);
          else               check("valid_at_t2", 16'(out_valid), 16'd1);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int fe_base;
    int ovf_base;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_data", 16'(out_data), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_corr_cnt", 16'(corr_cnt), 16'd0);
    check("rst_uncorr_cnt", 16'(uncorr_cnt), 16'd0);
    check("rst_pulses", 16'({frame_err, overflow}), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    sb.push_back({1'b0, 1'b0, 4'hA});
    send_frame(8'hA5, 1'b1, 1'b1, CW + 2);
    sb.push_back({1'b0, 1'b0, 4'h4});
    send_frame(8'h55, 1'b1, 1'b1, CW + 2);
    idle(10);
    check("clean_corr_cnt", 16'(corr_cnt), 16'd0);

    sb.push_back({1'b0, 1'b1, 4'hA});
    send_frame(8'h85, 1'b1, 1'b0, CW + 2);
    idle(10);
    check("corr_cnt_bit5", 16'(corr_cnt), 16'd1);
    sb.push_back({1'b0, 1'b1, 4'hA});
    send_frame(8'hA4, 1'b1, 1'b0, CW + 2);
    idle(10);
    check("corr_cnt_bit0", 16'(corr_cnt), 16'd2);

    sb.push_back({1'b1, 1'b0, 4'hC});
    send_frame(8'hC5, 1'b1, 1'b0, CW + 2);
    idle(10);
    check("uncorr_cnt", 16'(uncorr_cnt), 16'd1);
    check("corr_cnt_after_dbl", 16'(corr_cnt), 16'd2);

    out_ready = 1'b0;
    ovf_base  = ovf_seen;
    for (int i = 0; i < DEPTH; i++) sb.push_back({1'b0, 1'b0, 4'h4});
    for (int i = 0; i < 5; i++) send_frame(8'h55, 1'b1, 1'b0, CW + 2);
    idle(10);
    check("overflow_pulses", 16'(ovf_seen - ovf_base), 16'd1);
    check("full_valid", 16'(out_valid), 16'd1);
    check("held_head", 16'({out_uncorr, out_corr, out_data}), 16'h4);
    out_ready = 1'b1;
    idle(10);
    check("drained_valid", 16'(out_valid), 16'd0);
    check("drained_sb", 16'(sb.size()), 16'd0);

    fe_base = fe_seen;
    send_frame(8'hA5, 1'b0, 1'b0, CW + 2);
    serial_in = 1'b1;
    idle(20);
    check("frame_err_pulse", 16'(fe_seen - fe_base), 16'd1);
    check("frame_err_no_push", 16'(out_valid), 16'd0);

    fe_base  = fe_seen;
    ovf_base = ovf_seen;
    @(negedge clk);
    serial_in = 1'b0;
    idle(3);
    serial_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("glitch_busy", 16'(busy), 16'd1);
    repeat (20) @(posedge clk);
    #1;
    check("glitch_idle", 16'(busy), 16'd0);
    check("glitch_no_flags", 16'({fe_seen - fe_base, ovf_seen - ovf_base, 16'(out_valid)}), 16'd0);

    out_ready = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b0, CW + 2);
    send_frame(8'hC5, 1'b1, 1'b0, CW + 2);
    idle(10);
    check("pre_rst_valid", 16'(out_valid), 16'd1);
    check("pre_rst_uncorr_cnt", 16'(uncorr_cnt), 16'd2);
    fe_base  = fe_seen;
    ovf_base = ovf_seen;
    send_frame(8'hA5, 1'b1, 1'b0, 4);
    check("mid_frame_busy", 16'(busy), 16'd1);
    @(negedge clk);
    rst       = 1'b1;
    serial_in = 1'b1;
    idle(2);
    rst = 1'b0;
    #1;
    check("post_rst_valid", 16'(out_valid), 16'd0);
    check("post_rst_corr_cnt", 16'(corr_cnt), 16'd0);
    check("post_rst_uncorr_cnt", 16'(uncorr_cnt), 16'd0);
    check("post_rst_busy", 16'(busy), 16'd0);
    out_ready = 1'b1;
    idle(20);
    check("post_rst_no_pulse", 16'((fe_seen - fe_base) + (ovf_seen - ovf_base)), 16'd0);
    sb.push_back({1'b0, 1'b0, 4'hA});
    send_frame(8'hA5, 1'b1, 1'b1, CW + 2);
    idle(10);

    sb.push_back({1'b0, 1'b1, 4'hA});
    send_frame(8'h85, 1'b1, 1'b0, CW + 2);
    sb.push_back({1'b1, 1'b0, 4'hC});
    send_frame(8'hC5, 1'b1, 1'b0, CW + 2);
    idle(10);
    check("pre_clr_cnts", 16'({corr_cnt, uncorr_cnt}), 16'h0101);
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    check("cnt_clr", 16'({corr_cnt, uncorr_cnt}), 16'h0000);

    idle(5);
    check("final_sb_empty", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
